// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift/compare ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) into HI/LO registers.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MULU = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;

    localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH - 1);
    localparam logic [SHW:0] CNT_ONE   = (SHW+1)'(1);

    state_t           state;
    logic [SHW:0]     cnt;
    // opnd holds the multiplicand or the divisor for the whole operation;
    // work_hi/work_lo hold partial product, or remainder/dividend-quotient.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;

    assign shamt = B[SHW-1:0];

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
            OP_SLL:  alu_res = A << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add multiplicand when the current multiplier bit is
    // set, then shift the whole {carry, hi, lo} right by one.
    always_comb begin
        mul_sum    = {1'b0, work_hi} + {1'b0, opnd & {WIDTH{work_lo[0]}}};
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};
    end

    // One restoring step. A zero divisor always compares as "fits", which
    // naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        div_shift   = {work_hi, work_lo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, opnd};
        div_ge      = (div_shift >= {1'b0, opnd});
        div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_nxt = {work_lo[WIDTH-2:0], div_ge};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            opnd    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            C       <= '0;
            HI      <= '0;
            LO      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        case (ALUOp)
                            OP_MULU: begin
                                state   <= MUL;
                                busy    <= 1'b1;
                                opnd    <= A;
                                work_hi <= '0;
                                work_lo <= B;
                            end
                            OP_DIVU: begin
                                state   <= DIV;
                                busy    <= 1'b1;
                                opnd    <= B;
                                work_hi <= '0;
                                work_lo <= A;
                            end
                            default: begin
                                C    <= alu_res;
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    work_hi <= mul_hi_nxt;
                    work_lo <= mul_lo_nxt;
                    cnt     <= cnt + CNT_ONE;
                    if (cnt == LAST_ITER) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        HI    <= mul_hi_nxt;
                        LO    <= mul_lo_nxt;
                        C     <= mul_lo_nxt;
                    end
                end
                DIV: begin
                    work_hi <= div_rem_nxt;
                    work_lo <= div_quo_nxt;
                    cnt     <= cnt + CNT_ONE;
                    if (cnt == LAST_ITER) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        HI    <= div_rem_nxt;
                        LO    <= div_quo_nxt;
                        C     <= div_quo_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: 32-bit instance for the full op set,
// plus an 8-bit instance for the narrow-width multiply/divide.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [3:0]  ALUOp;
    logic [31:0] A, B, C, HI, LO;
    logic        busy, done;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, c8, hi8, lo8;
    logic        busy8, done8;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .A(A), .B(B),
        .C(C), .HI(HI), .LO(LO), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUOp(op8), .A(a8), .B(b8),
        .C(c8), .HI(hi8), .LO(lo8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves start high so consecutive calls are back-to-back.
    task automatic op1(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        start = 1'b1;
        ALUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        check(tag, 64'(C), 64'(exp));
        check({tag, "_done"}, 64'(done), 64'h1);
        check({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    // Multi-cycle op on the 32-bit instance; optional ignored start mid-run.
    task automatic mc(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_hi,
                      input logic [31:0] exp_lo, input bit poke);
        int n = 0;
        int guard = 0;
        start = 1'b1;
        ALUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        while (!done && guard < 100) begin
            start = 1'b0;
            if (busy) n++;
            if (poke && n == 10) begin
                start = 1'b1;
                ALUOp = 4'd0;
                A     = 32'h3;
                B     = 32'h5;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'd32);
        check({tag, "_done"}, 64'(done), 64'h1);
        check({tag, "_busy_end"}, 64'(busy), 64'h0);
        check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
        check({tag, "_c"}, 64'(C), 64'(exp_lo));
        @(negedge clk);
        check({tag, "_done_clear"}, 64'(done), 64'h0);
    endtask

    task automatic mc8(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int n = 0;
        int guard = 0;
        start8 = 1'b1;
        op8    = op;
        a8     = a;
        b8     = b;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && guard < 50) begin
            if (busy8) n++;
            @(negedge clk);
            guard++;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd8);
        check({tag, "_done"}, 64'(done8), 64'h1);
        check({tag, "_hi"}, 64'(hi8), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo8), 64'(exp_lo));
        check({tag, "_c"}, 64'(c8), 64'(exp_lo));
        @(negedge clk);
    endtask

    initial begin
        int dones;
        reset  = 1'b1;
        start  = 1'b0;
        ALUOp  = 4'd0;
        A      = '0;
        B      = '0;
        start8 = 1'b0;
        op8    = 4'd0;
        a8     = '0;
        b8     = '0;
        repeat (3) @(negedge clk);
        check("rst_c", 64'(C), 64'h0);
        check("rst_hi", 64'(HI), 64'h0);
        check("rst_lo", 64'(LO), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_c8", 64'(c8), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle ops, issued back-to-back.
        op1("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        op1("sub_wrap", 4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);
        op1("and", 4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        op1("or", 4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
        op1("sra", 4'd5, 32'h80000000, 32'h00000024, 32'hF8000000);
        op1("srl", 4'd4, 32'h80000000, 32'h00000024, 32'h08000000);
        op1("sll", 4'd6, 32'h00000001, 32'h00000024, 32'h00000010);
        op1("sll_upper_ignored", 4'd6, 32'h00000001, 32'h00000021, 32'h00000002);
        op1("slt_neg", 4'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        op1("sltu_big", 4'd8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        op1("slt_edge", 4'd7, 32'h7FFFFFFF, 32'h80000000, 32'h00000000);
        op1("sltu_edge", 4'd8, 32'h7FFFFFFF, 32'h80000000, 32'h00000001);
        op1("invalid_op", 4'd12, 32'h00000005, 32'h00000005, 32'h00000000);
        start = 1'b0;
        @(negedge clk);
        check("idle_done_clear", 64'(done), 64'h0);
        check("single_hi_kept", 64'(HI), 64'h0);
        check("single_lo_kept", 64'(LO), 64'h0);

        // Multi-cycle ops.
        mc("mulu_max", 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        mc("mulu_shift", 4'd9, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);
        mc("divu_100_7", 4'd10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        mc("divu_by_one", 4'd10, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 1'b0);
        mc("divu_by_zero", 4'd10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);

        op1("add_after_div", 4'd0, 32'd2, 32'd3, 32'd5);
        start = 1'b0;
        check("add_hi_kept", 64'(HI), 64'd5);
        check("add_lo_kept", 64'(LO), 64'hFFFFFFFF);
        @(negedge clk);

        // Reset ten cycles into a multiply, with a start at the same edge.
        start = 1'b1;
        ALUOp = 4'd9;
        A     = 32'hFFFFFFFF;
        B     = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'h1);
        reset = 1'b1;
        start = 1'b1;
        ALUOp = 4'd0;
        A     = 32'h1;
        B     = 32'h1;
        @(negedge clk);
        check("abort_c", 64'(C), 64'h0);
        check("abort_hi", 64'(HI), 64'h0);
        check("abort_lo", 64'(LO), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        reset = 1'b0;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'h0);
        check("abort_idle", 64'(busy), 64'h0);

        // Narrow instance.
        mc8("mulu8", 4'd9, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        mc8("divu8", 4'd10, 8'd200, 8'd9, 8'd2, 8'd22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
